// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle for spi_reg_bank.
// The master drives sclk/ncs/copi; the register-bank target drives cipo/cipo_oe.
interface spi_reg_bank_if;
    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
    modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 target that writes a bank of NUM_REGS x DATA_W
// configuration registers. The raw SPI pins are oversampled by clk.
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.
// The frame is evaluated when the synchronised ncs rises.
// Optional feature macro: SPI_READBACK_EN. When it is defined, a read frame shifts
// the addressed register out on cipo. When it is undefined, cipo and cipo_oe stay 0.
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam logic [CNT_W-1:0]  CNT_ADDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_FRAME     = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0]  CNT_SAT       = CNT_W'(FRAME + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W    = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, OVER} state_e;

    // Synchroniser chains: [0],[1] are the 2-flop synchroniser, [2] is the edge-detect history.
    logic [2:0] sclk_q, ncs_q, copi_q;
    logic       sclk_rise_q, ncs_rise_q, ncs_fall_q;
`ifdef SPI_READBACK_EN
    logic       sclk_fall_q;
`endif

    state_e                          state_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [FRAME-1:0]                sr_q, sr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;

    logic              frm_rw;
    logic [ADDR_W-1:0] frm_addr;
    logic [DATA_W-1:0] frm_data;
    logic              frm_addr_ok;

    // copi_q[2] is delayed to line up with the registered sclk_rise_q pulse.
    assign sr_d        = {sr_q[FRAME-2:0], copi_q[2]};
    assign frm_rw      = sr_q[FRAME-1];
    assign frm_addr    = sr_q[FRAME-2 -: ADDR_W];
    assign frm_data    = sr_q[DATA_W-1:0];
    assign frm_addr_ok = ({1'b0, frm_addr} < NUM_REGS_W);
    assign regs        = reg_q;

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] out_q, rd_word;
    logic              cipo_q, cipo_oe_q;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;

    // The command fields are taken from the value that the completing rising edge shifts in.
    assign cmd_rw   = sr_d[ADDR_W];
    assign cmd_addr = sr_d[ADDR_W-1:0];

    // Look up the register addressed by the command; out-of-range addresses read as zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd_word unassigned (no latch).
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_addr == ADDR_W'(k)) rd_word = reg_q[k];
        end
    end

    assign spi.cipo    = cipo_q;
    assign spi.cipo_oe = cipo_oe_q;
`else
    assign spi.cipo    = 1'b0;
    assign spi.cipo_oe = 1'b0;
`endif

    // Synchronise the raw SPI pins and register one-cycle edge pulses.
    // ncs history resets low, so ncs held low through reset release never looks like a falling edge.
    // In that case the FSM stays in IDLE until ncs has gone high and falls again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            ncs_q       <= '0;
            copi_q      <= '0;
            sclk_rise_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
`ifdef SPI_READBACK_EN
            sclk_fall_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
            sclk_q      <= {sclk_q[1:0], spi.sclk};
            ncs_q       <= {ncs_q[1:0], spi.ncs};
            copi_q      <= {copi_q[1:0], spi.copi};
            sclk_rise_q <= sclk_q[1] & ~sclk_q[2];
            ncs_rise_q  <= ncs_q[1] & ~ncs_q[2];
            ncs_fall_q  <= ~ncs_q[1] & ncs_q[2];
`ifdef SPI_READBACK_EN
            sclk_fall_q <= ~sclk_q[1] & sclk_q[2];
`endif
        end
    end

    // Frame FSM: bit counting, shifting, commit or discard on ncs rise, and optional shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            // NOTE: the register file is reset explicitly, because it drives chip controls that must power up off.
            reg_q     <= '0;
            wr_addr   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
`ifdef SPI_READBACK_EN
            out_q     <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (ncs_rise_q) begin
                // ncs rise has priority, so a coincident sclk rise is not counted.
                state_q <= IDLE;
                if (state_q != IDLE) begin
                    if (cnt_q == CNT_FRAME && frm_addr_ok) begin
                        if (frm_rw) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (frm_addr == ADDR_W'(k)) reg_q[k] <= frm_data;
                            end
                            wr_addr   <= frm_addr;
                            wr_strobe <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
`ifdef SPI_READBACK_EN
                cipo_q    <= 1'b0;
                cipo_oe_q <= 1'b0;
`endif
            end else if (ncs_fall_q) begin
                state_q <= CMD;
                cnt_q   <= '0;
                sr_q    <= '0;
            end else if (sclk_rise_q && state_q != IDLE) begin
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q < CNT_FRAME) sr_q <= sr_d;
                case (state_q)
                    CMD: begin
                        if (cnt_q == CNT_ADDR_LAST) begin
                            state_q <= DATA;
`ifdef SPI_READBACK_EN
                            if (!cmd_rw) begin
                                out_q     <= rd_word;
                                cipo_oe_q <= 1'b1;
                            end
`endif
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_FRAME) begin
                            state_q <= OVER;
`ifdef SPI_READBACK_EN
                            cipo_q    <= 1'b0;
                            cipo_oe_q <= 1'b0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
`ifdef SPI_READBACK_EN
            else if (sclk_fall_q && cipo_oe_q) begin
                cipo_q <= out_q[DATA_W-1];
                out_q  <= out_q << 1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard testbench for spi_reg_bank.
// It drives two instances that share sclk/copi and have separate ncs lines:
//   dut0 uses the default parameters (5 x 8-bit registers, 7-bit address).
//   dut1 uses 16 x 16-bit registers with a 4-bit address.
// The frame task updates a plain array model and pushes the expected commit or error
// event into a queue. A monitor pops that queue whenever a DUT pulses wr_strobe or frame_err.
module tb_spi_reg_bank;
    localparam int N0 = 5,  D0 = 8,  A0 = 7, F0 = 1 + A0 + D0;
    localparam int N1 = 16, D1 = 16, A1 = 4, F1 = 1 + A1 + D1;
    localparam int HALF = 5;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct {
        bit           is_err;
        int           addr;
        logic [255:0] regs;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk, copi, ncs0, ncs1;

    logic [N0*D0-1:0] regs0;
    logic [N1*D1-1:0] regs1;
    logic [A0-1:0]    wa0;
    logic [A1-1:0]    wa1;
    logic             ws0, ws1, fe0, fe1;

    int n_cmp = 0;
    int n_fail = 0;
    int unsigned mreg [2][16];
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;

    spi_reg_bank_if if0 ();
    spi_reg_bank_if if1 ();
    assign if0.sclk = sclk;
    assign if0.copi = copi;
    assign if0.ncs  = ncs0;
    assign if1.sclk = sclk;
    assign if1.copi = copi;
    assign if1.ncs  = ncs1;

    spi_reg_bank #(.NUM_REGS(N0), .DATA_W(D0), .ADDR_W(A0)) dut0 (
        .clk(clk), .rst_n(rst_n), .spi(if0.slave),
        .regs(regs0), .wr_strobe(ws0), .wr_addr(wa0), .frame_err(fe0)
    );
    spi_reg_bank #(.NUM_REGS(N1), .DATA_W(D1), .ADDR_W(A1)) dut1 (
        .clk(clk), .rst_n(rst_n), .spi(if1.slave),
        .regs(regs1), .wr_strobe(ws1), .wr_addr(wa1), .frame_err(fe1)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] snap(input int sel);
        logic [255:0] s;
        int nr;
        int dw;
        s  = '0;
        nr = sel ? N1 : N0;
        dw = sel ? D1 : D0;
        for (int k = 0; k < nr; k++)
            for (int b = 0; b < dw; b++)
                s[k*dw + b] = mreg[sel][k][b];
        return s;
    endfunction

    task automatic set_ncs(input int sel, input logic v);
        if (sel != 0) ncs1 = v;
        else ncs0 = v;
    endtask

    task automatic push_ev(input int sel, input bit is_err, input int addr);
        ev_t e;
        e.is_err = is_err;
        e.addr   = addr;
        e.regs   = snap(sel);
        if (sel != 0) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // One SPI frame. ld = -1/0/+1 gives a short, exact or overrun frame.
    task automatic frame(input int sel, input int rw, input int addr, input int data,
                         input int ld, input int gap);
        int aw, dw, fr, nr, nbits, rdv;
        logic [31:0] full, bits, rx, oe, exp_rx, exp_oe, mask;
        aw    = sel ? A1 : A0;
        dw    = sel ? D1 : D0;
        fr    = sel ? F1 : F0;
        nr    = sel ? N1 : N0;
        rw    = rw & 1;
        addr  = addr & ((1 << aw) - 1);
        data  = data & ((1 << dw) - 1);
        full  = (32'(rw) << (aw + dw)) | (32'(addr) << dw) | 32'(data);
        nbits = fr + ld;
        if (ld > 0) bits = {full[30:0], 1'($urandom_range(0, 1))};
        else if (ld < 0) bits = full >> 1;
        else bits = full;
        rdv = (addr < nr) ? int'(mreg[sel][addr]) : 0;
        for (int i = 0; i < 32; i++) begin
            exp_oe[i] = RB && rw == 0 && i > aw && i < fr;
            exp_rx[i] = exp_oe[i] ? rdv[dw - 1 - (i - 1 - aw)] : 1'b0;
            mask[i]   = i < nbits && i < fr;
        end
        rx = '0;
        oe = '0;
        set_ncs(sel, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits - 1 - i];
            repeat (HALF) @(negedge clk);
            rx[i] = sel ? if1.cipo : if0.cipo;
            oe[i] = sel ? if1.cipo_oe : if0.cipo_oe;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        check($sformatf("dut%0d cipo bits (rw=%0d addr=%0d len=%0d)", sel, rw, addr, nbits),
              256'(rx & mask), 256'(exp_rx));
        check($sformatf("dut%0d cipo_oe bits (rw=%0d addr=%0d len=%0d)", sel, rw, addr, nbits),
              256'(oe & mask), 256'(exp_oe));
        if (nbits == fr && addr < nr) begin
            if (rw != 0) begin
                mreg[sel][addr] = data;
                push_ev(sel, 1'b0, addr);
            end
        end else begin
            push_ev(sel, 1'b1, 0);
        end
        set_ncs(sel, 1'b1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic mon(input int sel, input logic ws, input logic fe,
                       input logic [255:0] r, input int wa);
        ev_t e;
        if (!(ws || fe)) return;
        if ((sel == 0 && q0.size() == 0) || (sel != 0 && q1.size() == 0)) begin
            check($sformatf("dut%0d unexpected {wr_strobe,frame_err}", sel), 256'({ws, fe}), 256'(0));
            return;
        end
        if (sel != 0) e = q1.pop_front();
        else e = q0.pop_front();
        check($sformatf("dut%0d wr_strobe", sel), 256'(ws), 256'(!e.is_err));
        check($sformatf("dut%0d frame_err", sel), 256'(fe), 256'(e.is_err));
        if (!e.is_err) check($sformatf("dut%0d wr_addr", sel), 256'(wa), 256'(e.addr));
        check($sformatf("dut%0d regs", sel), r, e.regs);
    endtask

    // Monitor: compare each output event against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ws0, fe0, 256'(regs0), int'(wa0));
            mon(1, ws1, fe1, 256'(regs1), int'(wa1));
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, " regs0"}, 256'(regs0), 256'(0));
        check({tag, " regs1"}, 256'(regs1), 256'(0));
        check({tag, " wr_addr0"}, 256'(wa0), 256'(0));
        check({tag, " strobe/err"}, 256'({ws0, fe0, ws1, fe1}), 256'(0));
        check({tag, " cipo/oe"}, 256'({if0.cipo, if0.cipo_oe, if1.cipo, if1.cipo_oe}), 256'(0));
    endtask

    // Stimulus: directed cases first, then randomized frames.
    initial begin
        int ld;
        sclk = 1'b0;
        copi = 1'b0;
        ncs0 = 1'b1;
        ncs1 = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 16; k++) mreg[s][k] = 0;
        repeat (4) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        frame(0, 1, 4, 'hA5, 0, 8);
        check("A5 write leaves other regs 0", 256'(regs0), 256'(40'hA5_0000_0000));

        frame(0, 1, 1, 'h77, -1, 8);
        frame(0, 1, 1, 'h77, 1, 8);
        frame(0, 1, 7, 'h77, 0, 8);

        for (int i = 0; i < 12; i++) begin
            copi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        frame(0, 1, 0, 'h11, 0, 3);
        frame(0, 1, 3, 'hC8, 0, 8);

        frame(0, 1, 2, 'h3C, 0, 8);
        frame(0, 0, 2, 0, 0, 8);
        frame(0, 0, 9, 0, 0, 8);

        // Reset mid-frame, then release reset while ncs is still low.
        ncs0 = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            copi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 16; k++) mreg[s][k] = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("mid-frame reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        ncs0 = 1'b1;
        repeat (12) @(negedge clk);
        frame(0, 1, 4, 'h5A, 0, 8);

        frame(1, 1, 15, 'hBEEF, 0, 8);
        check("dut1 reg15", 256'(regs1[255:240]), 256'(16'hBEEF));
        frame(1, 0, 15, 0, 0, 8);

        for (int n = 0; n < 60; n++) begin
            ld = $urandom_range(0, 9);
            ld = (ld == 0) ? -1 : (ld == 1) ? 1 : 0;
            frame(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), ld, int'($urandom_range(3, 10)));
        end
        for (int n = 0; n < 20; n++) begin
            ld = $urandom_range(0, 9);
            ld = (ld == 0) ? -1 : (ld == 1) ? 1 : 0;
            frame(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 65535)), ld, int'($urandom_range(3, 10)));
        end

        repeat (20) @(negedge clk);
        check("dut0 pending expected events", 256'(q0.size()), 256'(0));
        check("dut1 pending expected events", 256'(q1.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end
endmodule
